// File: rtl/mc_rtype_pkg.sv
// Shared types and constants for the multi-cycle R-type core.
// Covers the FSM states, the R-type funct codes and the ALU operation decode.
package mc_rtype_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NONE
  } alu_op_t;

  // ALU_NONE marks every encoding the core does not implement.
  function automatic alu_op_t decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    decode_op = ALU_NONE;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  decode_op = ALU_ADD;
        FN_SUB:  decode_op = ALU_SUB;
        FN_AND:  decode_op = ALU_AND;
        FN_OR:   decode_op = ALU_OR;
        FN_SLT:  decode_op = ALU_SLT;
        default: decode_op = ALU_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/mc_rtype_regfile.sv
// XLEN x NREG register file: two asynchronous read ports, one synchronous write port.
// Register 0 is never written and always reads as zero.
module mc_rtype_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_rtype_core.sv
// Multi-cycle R-type core: FETCH/WAIT/DECODE/EXEC/WB sequencing around a register file.
// Write-back, illegal and pc updates are registered, so they appear the cycle after WB.
module mc_rtype_core
  import mc_rtype_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int          NREG    = 32,
  parameter int          IMEM_AW = 8,
  parameter int unsigned PC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        imem_rdata,
  input  logic               dbg_we,
  input  logic [4:0]         dbg_addr,
  input  logic [XLEN-1:0]    dbg_wdata,
  output logic               wb_valid,
  output logic [4:0]         wb_addr,
  output logic [XLEN-1:0]    wb_data,
  output logic               illegal,
  output logic [31:0]        pc,
  output logic               busy
);

  localparam int          AW     = $clog2(NREG);
  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  state_t          state, state_next;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, alu_q, alu_res;
  logic [XLEN-1:0] rd1, rd2;
  alu_op_t         alu_op;
  logic            legal;
  logic [AW-1:0]   rd_idx;
  logic            wb_commit, dbg_commit;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            unused_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // run is only looked at in IDLE and WB, so an instruction in flight always completes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = FETCH;
      FETCH:   state_next = WAIT;
      WAIT:    if (imem_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = run ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH);
    busy     = (state != IDLE);
  end

  assign imem_addr    = pc[IMEM_AW+1:2];
  assign alu_op       = decode_op(ir[31:26], ir[5:0]);
  assign legal        = (alu_op != ALU_NONE);
  assign rd_idx       = ir[11 +: AW];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // The debug port and write-back share the single write port; they never overlap in time.
  assign wb_commit  = (state == WB) && legal && (rd_idx != '0);
  assign dbg_commit = (state == IDLE) && dbg_we;
  assign rf_we      = wb_commit || dbg_commit;
  assign rf_wa      = (state == IDLE) ? dbg_addr[AW-1:0] : rd_idx;
  assign rf_wd      = (state == IDLE) ? dbg_wdata : alu_q;

  mc_rtype_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[21 +: AW]),
    .ra2 (ir[16 +: AW]),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      alu_q <= '0;
    end else begin
      if ((state == WAIT) && imem_valid) ir <= imem_rdata;
      if (state == DECODE) begin
        a <= rd1;
        b <= rd2;
      end
      if (state == EXEC) alu_q <= alu_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= wb_commit;
      illegal  <= (state == WB) && !legal;
      if (wb_commit) begin
        wb_addr <= ir[15:11];
        wb_data <= alu_q;
      end
      if (state == WB) pc <= pc + PC_INC;
    end
  end

endmodule

// File: tb/tb_mc_rtype_core.sv
// Self-checking bench for mc_rtype_core: directed vector table, randomized stream
// against a register-array model, and hand-written control/reset/wrap sequences.
module tb_mc_rtype_core;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        wb_valid, illegal, busy;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, pc;

  logic        run2, req2, valid2, wbv2, ill2, busy2;
  logic [7:0]  addr2;
  logic [31:0] rdata2, wbd2, pc2;
  logic [4:0]  wba2;

  always #5 clk = ~clk;

  mc_rtype_core dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .pc(pc), .busy(busy)
  );

  // Second instance with a huge pc step so the 32-bit wrap is reachable in two instructions.
  mc_rtype_core #(.PC_STEP(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .run(run2),
    .imem_req(req2), .imem_addr(addr2), .imem_valid(valid2), .imem_rdata(rdata2),
    .dbg_we(1'b0), .dbg_addr(5'd0), .dbg_wdata(32'd0),
    .wb_valid(wbv2), .wb_addr(wba2), .wb_data(wbd2),
    .illegal(ill2), .pc(pc2), .busy(busy2)
  );

  typedef struct packed {
    logic        legal;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    int          delay;
    bit          ghost;
    bit          exp_wb;
    bit          exp_ill;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  logic [31:0] model_regs [32];
  logic [31:0] model_pc;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_pc = 32'd0;
  endtask

  // Architectural meaning of one instruction against the current model registers.
  function automatic exp_t modelExec(input logic [31:0] instr);
    exp_t        e;
    logic [31:0] x, y;
    x       = model_regs[instr[25:21]];
    y       = model_regs[instr[20:16]];
    e.legal = 1'b1;
    e.data  = 32'd0;
    if (instr[31:26] != 6'd0) e.legal = 1'b0;
    else begin
      case (instr[5:0])
        6'h20:   e.data = x + y;
        6'h22:   e.data = x - y;
        6'h24:   e.data = x & y;
        6'h25:   e.data = x | y;
        6'h2A:   e.data = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        default: e.legal = 1'b0;
      endcase
    end
    e.addr = instr[15:11];
    e.wr   = e.legal && (e.addr != 5'd0);
    return e;
  endfunction

  task automatic dbgWrite(input logic [4:0] addr, input logic [31:0] data);
    dbg_we    = 1'b1;
    dbg_addr  = addr;
    dbg_wdata = data;
    @(negedge clk);
    dbg_we = 1'b0;
    if (addr != 5'd0) model_regs[addr] = data;
  endtask

  // Serves one fetch and follows the instruction to completion (pc change).
  task automatic applyStimulus(input logic [31:0] instr, input int delay, input int stop_cycle,
                               input bit ghost, input bit poke,
                               output bit obs_wb, output logic [4:0] obs_addr,
                               output logic [31:0] obs_data, output bit obs_ill);
    int          cyc;
    logic [31:0] pc_before;
    obs_wb = 1'b0; obs_addr = 5'd0; obs_data = 32'd0; obs_ill = 1'b0;
    cyc = 0;
    while (!imem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!imem_req) begin
      checkOutput("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("imem_addr", {24'd0, imem_addr}, {24'd0, model_pc[9:2]});
    pc_before = pc;
    cyc = 0;
    forever begin
      if (cyc == stop_cycle) run = 1'b0;
      if (poke && cyc == 2) begin
        dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'hDEAD_0006;
      end
      if (poke && cyc == 3) dbg_we = 1'b0;
      if (cyc == delay + 1) begin
        imem_valid = 1'b1; imem_rdata = instr;
      end else if (cyc == delay + 2 && ghost) begin
        imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      end else imem_valid = 1'b0;
      @(negedge clk);
      cyc++;
      if (pc !== pc_before || cyc > 40) break;
    end
    imem_valid = 1'b0;
    dbg_we     = 1'b0;
    if (cyc > 40) begin
      checkOutput("completion_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", 32'(cyc), 32'(5 + delay));
    model_pc = model_pc + 32'd4;
    checkOutput("pc", pc, model_pc);
    obs_wb = wb_valid; obs_addr = wb_addr; obs_data = wb_data; obs_ill = illegal;
  endtask

  task automatic checkInstr(input logic [31:0] instr, input int delay, input int stop_cycle,
                            input bit ghost, input bit poke);
    exp_t        e;
    bit          w, il;
    logic [4:0]  ad;
    logic [31:0] d;
    e = modelExec(instr);
    applyStimulus(instr, delay, stop_cycle, ghost, poke, w, ad, d, il);
    checkOutput("wb_valid", {31'd0, w}, {31'd0, e.wr});
    checkOutput("illegal", {31'd0, il}, {31'd0, !e.legal});
    if (e.wr) begin
      checkOutput("wb_addr", {27'd0, ad}, {27'd0, e.addr});
      checkOutput("wb_data", d, e.data);
      model_regs[e.addr] = e.data;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pc"}, pc, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    checkOutput({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
    checkOutput({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    checkOutput({tag, "_wb_addr"}, {27'd0, wb_addr}, 32'd0);
    checkOutput({tag, "_wb_data"}, wb_data, 32'd0);
    checkOutput({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          w, il;
    logic [4:0]  ad;
    logic [31:0] d;
    logic [31:0] instr;
    int          n;
    bit          saw_wb;
    logic [31:0] p0;
    logic [5:0]  fn_list [5];

    vecs[0]  = '{32'h0022_1820, 32'd5,          32'd7,          0, 1'b0, 1'b1, 1'b0, 5'd3, 32'd12};
    vecs[1]  = '{32'h0022_2022, 32'd3,          32'hFFFF_FFFF,  0, 1'b0, 1'b1, 1'b0, 5'd4, 32'd4};
    vecs[2]  = '{32'h0022_282A, 32'd3,          32'hFFFF_FFFF,  0, 1'b0, 1'b1, 1'b0, 5'd5, 32'd0};
    vecs[3]  = '{32'h0041_282A, 32'd3,          32'hFFFF_FFFF,  0, 1'b0, 1'b1, 1'b0, 5'd5, 32'd1};
    vecs[4]  = '{32'h0022_1820, 32'd5,          32'd7,          3, 1'b0, 1'b1, 1'b0, 5'd3, 32'd12};
    vecs[5]  = '{32'h0022_1820, 32'd20,         32'd22,         0, 1'b1, 1'b1, 1'b0, 5'd3, 32'd42};
    vecs[6]  = '{32'h0022_1827, 32'd1,          32'd2,          0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0};
    vecs[7]  = '{32'h0022_0020, 32'd1,          32'd2,          0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    vecs[8]  = '{32'h0000_1820, 32'd9,          32'd9,          0, 1'b0, 1'b1, 1'b0, 5'd3, 32'd0};
    vecs[9]  = '{32'h0022_3024, 32'hF0F0_F0F0,  32'hFF00_FF00,  1, 1'b0, 1'b1, 1'b0, 5'd6, 32'hF000_F000};
    vecs[10] = '{32'h0022_3825, 32'h0F0F_0000,  32'h0000_00F1,  0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0F0F_00F1};
    vecs[11] = '{32'h2022_1820, 32'd1,          32'd2,          0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0};
    vecs[12] = '{32'h0022_1820, 32'hFFFF_FFFF,  32'd2,          2, 1'b0, 1'b1, 1'b0, 5'd3, 32'd1};
    fn_list[0] = 6'h20; fn_list[1] = 6'h22; fn_list[2] = 6'h24; fn_list[3] = 6'h25; fn_list[4] = 6'h2A;

    rst = 1'b1; run = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    run2 = 1'b0; valid2 = 1'b0; rdata2 = 32'd0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: each vector loads r1/r2 in IDLE and runs a single instruction.
    for (int i = 0; i < 13; i++) begin
      dbgWrite(5'd1, vecs[i].r1);
      dbgWrite(5'd2, vecs[i].r2);
      run = 1'b1;
      applyStimulus(vecs[i].instr, vecs[i].delay, 0, vecs[i].ghost, 1'b0, w, ad, d, il);
      checkOutput($sformatf("vec%0d_wb_valid", i), {31'd0, w}, {31'd0, vecs[i].exp_wb});
      checkOutput($sformatf("vec%0d_illegal", i), {31'd0, il}, {31'd0, vecs[i].exp_ill});
      if (vecs[i].exp_wb) begin
        checkOutput($sformatf("vec%0d_wb_addr", i), {27'd0, ad}, {27'd0, vecs[i].exp_addr});
        checkOutput($sformatf("vec%0d_wb_data", i), d, vecs[i].exp_data);
        model_regs[vecs[i].exp_addr] = vecs[i].exp_data;
      end
      checkOutput($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // Randomized back-to-back stream against the model.
    for (int r = 1; r < 32; r++) dbgWrite(5'(r), $urandom);
    run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      instr = $urandom;
      instr[31:26] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      instr[5:0]   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 4)];
      checkInstr(instr, $urandom_range(0, 2), (k == 39) ? 0 : -1, 1'($urandom_range(0, 1)), 1'b0);
    end
    checkOutput("stream_busy_after", {31'd0, busy}, 32'd0);

    // run dropped during EXEC plus a debug write attempted while busy.
    dbgWrite(5'd6, 32'h0000_1234);
    run = 1'b1;
    checkInstr(32'h00C0_3825, 0, 3, 1'b0, 1'b1);
    checkOutput("run_drop_busy", {31'd0, busy}, 32'd0);
    checkOutput("run_drop_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("run_drop_idle_hold", {31'd0, busy}, 32'd0);
    run = 1'b1;
    checkInstr(32'h00C0_3825, 0, 0, 1'b0, 1'b0);

    // Reset asserted in EXEC aborts the instruction.
    dbgWrite(5'd1, 32'd9);
    dbgWrite(5'd2, 32'd1);
    run = 1'b1;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_fetch_seen", {31'd0, imem_req}, 32'd1);
    run = 1'b0;
    @(negedge clk); imem_valid = 1'b1; imem_rdata = 32'h0022_1820;
    @(negedge clk); imem_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetOutputs("abort");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    saw_wb = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wb_valid) saw_wb = 1'b1;
    end
    checkOutput("abort_no_wb", {31'd0, saw_wb}, 32'd0);
    run = 1'b1;
    checkInstr(32'h0022_1820, 0, 0, 1'b0, 1'b0);

    // pc wrap on the wide-step instance.
    run2 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!req2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("wrap_imem_addr", {24'd0, addr2}, (k == 0) ? 32'h0 : 32'hFF);
      if (k == 1) run2 = 1'b0;
      p0 = pc2;
      @(negedge clk); valid2 = 1'b1; rdata2 = 32'h0000_0020;
      @(negedge clk); valid2 = 1'b0;
      n = 0;
      while (pc2 === p0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("wrap_pc", pc2, (k == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_rtype_core.md
# mc_rtype_core

Parametrised multi-cycle R-type processor core: fetches 32-bit MIPS-format instructions over a valid/request memory interface, reads two registers, executes add/sub/and/or/slt and writes back. It is the successor to the single-cycle PC/instruction-memory/register-file/ALU datapath. This version has configurable width and register count, a wait-state-tolerant fetch, a run/idle control and a debug register-load port. It sits between the instruction memory and any write-back observer or trace logic.

## Interface
- XLEN, 32, datapath and register width (≥8)
- NREG, 32, register count (power of 2, ≤32); register index = low log2(NREG) bits of each 5-bit field
- IMEM_AW, 8, instruction-memory word-address width
- PC_STEP, 4, byte increment per instruction
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; high starts/continues execution
- imem_req  out  1  fetch request pulse
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_valid  in  1  instruction data valid
- imem_rdata  in  32  instruction word
- dbg_we  in  1  debug register write, honoured only in IDLE
- dbg_addr  in  5  debug register index
- dbg_wdata  in  XLEN  debug write data
- wb_valid  out  1  one-cycle pulse on architectural write-back
- wb_addr  out  5  destination register of that write-back
- wb_data  out  XLEN  value written
- illegal  out  1  one-cycle pulse for an unsupported instruction
- pc  out  32  current program counter
- busy  out  1  high in every state except IDLE

## Operation
- Decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
- Legal instructions require opcode 0 and one of these funct values:
  - 0x20 ADD: wrapping addition mod 2^XLEN
  - 0x22 SUB: wrapping subtraction
  - 0x24 AND
  - 0x25 OR
  - 0x2A SLT: signed compare; result 1 if rs<rt, else 0, zero-extended
- Anything else is illegal: pulse illegal in WB, no register write, pc still advances.
- Register 0 reads as 0. Writes to register 0, whether from rd or debug, are discarded and wb_valid stays low.
- State machine:
  - IDLE: run=1 → FETCH. dbg_we writes the register file here.
  - FETCH: imem_req=1 for exactly one cycle → WAIT.
  - WAIT: hold until imem_valid=1, latch IR → DECODE. imem_valid is ignored in every other state.
  - DECODE: latch A=R[rs], B=R[rt] → EXEC.
  - EXEC: latch the ALU result → WB.
  - WB: write R[rd], pulse wb_valid/wb_addr/wb_data, pc ← pc+PC_STEP (wraps mod 2^32); run=1 → FETCH, else IDLE.
- run=0 is sampled only in IDLE and WB. An instruction in flight always completes.
- dbg_we outside IDLE is ignored.

## Timing
- Reset values: state IDLE, pc=0, all registers 0, imem_req=0, imem_addr=0, wb_valid=0, wb_addr=0, wb_data=0, illegal=0, busy=0.
- Minimum latency is 5 cycles per instruction (FETCH, WAIT, DECODE, EXEC, WB), with imem_valid high the cycle after imem_req. Each extra WAIT cycle adds 1.
- Write-back is visible to the next instruction's DECODE; no bypass is needed.
- A debug write in IDLE is readable from the next cycle.
- Reset asserted mid-instruction aborts it immediately: no write-back, pc=0, registers cleared.

## Structure
- Package mc_rtype_pkg holds:
  - state enum {IDLE, FETCH, WAIT, DECODE, EXEC, WB}
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT)
  - ALU op enum
- Sub-module mc_rtype_regfile: parametrised XLEN×NREG register file with 2 asynchronous read ports and 1 synchronous write port, async reset, register 0 forced to zero.
- ALU and decode logic stay inside the core.

## Test plan
- Reset, dbg-load R1=5, R2=7, run=1, fetch 0x00221820 (ADD r3,r1,r2) → wb_valid with wb_addr=3, wb_data=12, exactly 5 cycles after the first imem_req; pc=4.
- XLEN=32, R1=0x00000003, R2=0xFFFFFFFF: SUB r4,r1,r2 → wb_data=4; SLT r5,r1,r2 → wb_data=0; SLT r5,r2,r1 → wb_data=1.
- imem_valid delayed 3 cycles → 8 cycles to write-back; imem_valid pulses in DECODE are ignored.
- Instruction 0x00221827 (NOR) → illegal pulse, no wb_valid, pc advances by 4. Instruction with rd=0 → no wb_valid, R0 still reads 0.
- run dropped during EXEC → WB completes, state IDLE, busy=0. dbg_we while busy has no effect.
- rst asserted during EXEC → outputs return to reset values asynchronously and no write-back occurs. Separately, with pc preset near 0xFFFFFFFC, pc wraps to 0.
